// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue/write-back controller.
//   WIDTH / N_REGS : data width and register file depth (fixed 4 / 4)
//   F_*            : ALU function codes driven on alu_f
//   state_t        : controller FSM states
package alu_issue_ctrl_pkg;

    localparam int unsigned WIDTH  = 4;
    localparam int unsigned N_REGS = 4;
    localparam int unsigned IDX_W  = 2;

    // F[1:0] selects the operation class; F[2] is the modifier bit.
    localparam logic [2:0] F_AND  = 3'b000;
    localparam logic [2:0] F_OR   = 3'b001;
    localparam logic [2:0] F_ADD  = 3'b010;
    localparam logic [2:0] F_GT   = 3'b011;
    localparam logic [2:0] F_ANDN = 3'b100;
    localparam logic [2:0] F_ORN  = 3'b101;
    localparam logic [2:0] F_SUB  = 3'b110;
    localparam logic [2:0] F_EQ   = 3'b111;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StWb   = 2'b10
    } state_t;

endpackage

// File: rtl/regfile_4x4.sv
// 4-entry x 4-bit register file.
//   clk, rst         : clock, synchronous active-high reset (clears all entries)
//   rd_idx_a/rd_data_a, rd_idx_b/rd_data_b : asynchronous read ports
//   we, wr_idx, wr_data                     : synchronous write port
module regfile_4x4
    import alu_issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [IDX_W-1:0] rd_idx_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] regs_q [N_REGS];
    logic [WIDTH-1:0] regs_d [N_REGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[wr_idx] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd_data_a = regs_q[rd_idx_a];
    assign rd_data_b = regs_q[rd_idx_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/write-back controller feeding a 4-bit combinational ALU.
// One instruction per three cycles: accept (IDLE) -> EXEC -> WB.
//   clk, rst                  : clock, synchronous active-high reset
//   in_valid/in_ready         : instruction handshake (ready only in IDLE)
//   in_ld, in_f, in_rd, in_ra, in_rb, in_imm_en, in_imm : instruction fields
//   alu_a, alu_b, alu_f       : registered ALU operands/function
//   alu_y                     : combinational ALU result
//   wb_valid, wb_rd, wb_data  : register write-back pulse
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_ld,
    input  logic [2:0]       in_f,
    input  logic [IDX_W-1:0] in_rd,
    input  logic [IDX_W-1:0] in_ra,
    input  logic [IDX_W-1:0] in_rb,
    input  logic             in_imm_en,
    input  logic [WIDTH-1:0] in_imm,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    output logic             wb_valid,
    output logic [IDX_W-1:0] wb_rd,
    output logic [WIDTH-1:0] wb_data
);

    state_t           state_q, state_d;
    logic             ld_q, ld_d;
    logic [IDX_W-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_f_q, alu_f_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] rf_data_a;
    logic [WIDTH-1:0] rf_data_b;

    regfile_4x4 u_regfile (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_a  (in_ra),
        .rd_data_a (rf_data_a),
        .rd_idx_b  (in_rb),
        .rd_data_b (rf_data_b),
        .we        (wb_valid),
        .wr_idx    (rd_q),
        .wr_data   (result_q)
    );

    always_comb begin
        state_d  = state_q;
        ld_d     = ld_q;
        rd_d     = rd_q;
        imm_d    = imm_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_f_d  = alu_f_q;
        result_d = result_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    ld_d    = in_ld;
                    rd_d    = in_rd;
                    imm_d   = in_imm;
                    alu_a_d = rf_data_a;
                    alu_b_d = in_imm_en ? in_imm : rf_data_b;
                    alu_f_d = in_f;
                    state_d = StExec;
                end
            end
            StExec: begin
                // Loads still pass through EXEC so latency is uniform; alu_y is ignored.
                result_d = ld_q ? imm_q : alu_y;
                state_d  = StWb;
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ld_q     <= 1'b0;
            rd_q     <= '0;
            imm_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_f_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ld_q     <= ld_d;
            rd_q     <= rd_d;
            imm_q    <= imm_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_f_q  <= alu_f_d;
            result_q <= result_d;
        end
    end

    // Reset gates the handshake and write-back in the cycle it is asserted, so an
    // in-flight instruction in WB is dropped rather than committed.
    assign in_ready = (state_q == StIdle) && !rst;
    assign wb_valid = (state_q == StWb) && !rst;
    assign wb_rd    = wb_valid ? rd_q : '0;
    assign wb_data  = wb_valid ? result_q : '0;

    assign alu_a = alu_a_q;
    assign alu_b = alu_b_q;
    assign alu_f = alu_f_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl. Provides the combinational ALU and a
// reference model: an array of register values plus arithmetic ALU semantics.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_ld;
    logic [2:0] in_f;
    logic [1:0] in_rd, in_ra, in_rb;
    logic       in_imm_en;
    logic [3:0] in_imm;
    logic [3:0] alu_a, alu_b, alu_y;
    logic [2:0] alu_f;
    logic       wb_valid;
    logic [1:0] wb_rd;
    logic [3:0] wb_data;

    int n_cmp = 0;
    int n_err = 0;
    int ref_r [4];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ld     (in_ld),
        .in_f      (in_f),
        .in_rd     (in_rd),
        .in_ra     (in_ra),
        .in_rb     (in_rb),
        .in_imm_en (in_imm_en),
        .in_imm    (in_imm),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    // Behavioural ALU: integer arithmetic reduced modulo 16.
    function automatic int alu_ref(input int a, input int b, input int f);
        int nb;
        nb = 15 - b;
        case (f % 4)
            0:       return (f >= 4) ? (a & nb) : (a & b);
            1:       return (f >= 4) ? (a | nb) : (a | b);
            2:       return (f >= 4) ? (a - b + 16) % 16 : (a + b) % 16;
            default: return (f >= 4) ? int'(a == b) : int'(a > b);
        endcase
    endfunction

    assign alu_y = 4'(alu_ref(int'(alu_a), int'(alu_b), int'(alu_f)));

    task automatic chk(input string name, input int act, input int exp);
        // Only used for formatting inside callers' comparisons below.
        $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction from IDLE and follow it through EXEC and WB.
    // exp_lit >= 0 additionally checks the write-back data against a literal.
    task automatic issue(input logic ld, input logic [2:0] f, input logic [1:0] rd,
                         input logic [1:0] ra, input logic [1:0] rb, input logic imm_en,
                         input logic [3:0] imm, input int exp_lit, input string name);
        int ea, eb, eres;
        ea   = ref_r[ra];
        eb   = imm_en ? int'(imm) : ref_r[rb];
        eres = ld ? int'(imm) : alu_ref(ea, eb, int'(f));
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; chk({name, "_ready_idle"}, in_ready, 1); end
        in_valid = 1'b1; in_ld = ld; in_f = f; in_rd = rd; in_ra = ra; in_rb = rb;
        in_imm_en = imm_en; in_imm = imm;
        tick();
        // EXEC: scramble inputs to prove the latched copies are used.
        in_valid = 1'b0; in_ld = ~ld; in_f = 3'($urandom); in_rd = 2'($urandom);
        in_ra = 2'($urandom); in_rb = 2'($urandom); in_imm = 4'($urandom);
        n_cmp += 4;
        if (in_ready !== 1'b0) begin n_err++; chk({name, "_ready_exec"}, in_ready, 0); end
        if (wb_valid !== 1'b0) begin n_err++; chk({name, "_wbv_exec"}, wb_valid, 0); end
        if (alu_a !== 4'(ea)) begin n_err++; chk({name, "_alu_a"}, alu_a, ea); end
        if (alu_b !== 4'(eb) || alu_f !== f) begin
            n_err++; chk({name, "_alu_bf"}, {alu_f, alu_b}, {f, 4'(eb)});
        end
        tick();
        n_cmp += 4;
        if (wb_valid !== 1'b1) begin n_err++; chk({name, "_wb_valid"}, wb_valid, 1); end
        if (wb_rd !== rd) begin n_err++; chk({name, "_wb_rd"}, wb_rd, rd); end
        if (wb_data !== 4'(eres)) begin n_err++; chk({name, "_wb_data"}, wb_data, eres); end
        if (in_ready !== 1'b0) begin n_err++; chk({name, "_ready_wb"}, in_ready, 0); end
        if (exp_lit >= 0) begin
            n_cmp++;
            if (wb_data !== 4'(exp_lit)) begin
                n_err++; chk({name, "_wb_lit"}, wb_data, exp_lit);
            end
        end
        ref_r[rd] = eres;
        tick();
        n_cmp += 2;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; chk({name, "_idle_after"}, {wb_valid, in_ready}, 1);
        end
        if (alu_a !== 4'(ea) || alu_b !== 4'(eb)) begin
            n_err++; chk({name, "_alu_retain"}, {alu_a, alu_b}, {4'(ea), 4'(eb)});
        end
        in_ld = 1'b0; in_imm_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_ld = 1'b0; in_f = '0; in_rd = '0; in_ra = '0;
        in_rb = '0; in_imm_en = 1'b0; in_imm = '0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b0) begin
            n_err++; chk("reset_during", {in_ready, wb_valid}, 0);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp += 3;
        if (in_ready !== 1'b1) begin n_err++; chk("reset_ready", in_ready, 1); end
        if ({alu_a, alu_b, alu_f} !== 11'd0) begin
            n_err++; chk("reset_alu", {alu_a, alu_b, alu_f}, 0);
        end
        if ({wb_valid, wb_rd, wb_data} !== 7'd0) begin
            n_err++; chk("reset_wb", {wb_valid, wb_rd, wb_data}, 0);
        end
        for (int i = 0; i < 4; i++) ref_r[i] = 0;
    endtask

    task automatic test_directed();
        issue(1'b1, F_AND, 2'd0, 2'd0, 2'd0, 1'b0, 4'd5, 5, "ld_r0");
        issue(1'b1, F_AND, 2'd1, 2'd0, 2'd0, 1'b0, 4'd3, 3, "ld_r1");
        issue(1'b0, F_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0, 8, "add");
        issue(1'b0, F_SUB, 2'd3, 2'd1, 2'd0, 1'b0, 4'd0, 14, "sub");
        issue(1'b0, F_GT,  2'd3, 2'd0, 2'd1, 1'b0, 4'd0, 1, "gt");
        issue(1'b0, F_EQ,  2'd3, 2'd1, 2'd1, 1'b0, 4'd0, 1, "eq_same");
        issue(1'b0, F_EQ,  2'd3, 2'd0, 2'd1, 1'b0, 4'd0, 0, "eq_diff");
        issue(1'b0, F_ANDN, 2'd3, 2'd0, 2'd2, 1'b1, 4'd3, 4, "andn_imm");
        issue(1'b0, F_OR,  2'd3, 2'd1, 2'd0, 1'b0, 4'd0, 7, "or");
        issue(1'b0, F_ORN, 2'd3, 2'd1, 2'd0, 1'b1, 4'hE, 3, "orn_imm");
        issue(1'b1, F_AND, 2'd0, 2'd0, 2'd0, 1'b0, 4'd9, 9, "ld_r0_9");
        issue(1'b0, F_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 4'd9, 2, "add_wrap");
        issue(1'b1, F_AND, 2'd0, 2'd0, 2'd0, 1'b0, 4'd5, 5, "ld_r0_5");
    endtask

    // in_valid held for six cycles with a dependent pair: R2=R0+R1, then R2=R2+R2.
    task automatic test_back_to_back();
        int accepts;
        accepts = 0;
        in_valid = 1'b1; in_ld = 1'b0; in_f = F_ADD; in_rd = 2'd2; in_ra = 2'd0;
        in_rb = 2'd1; in_imm_en = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) begin in_ra = 2'd2; in_rb = 2'd2; end
            n_cmp += 2;
            if (in_ready !== ((c % 3) == 0)) begin
                n_err++; chk($sformatf("b2b_ready_c%0d", c), in_ready, (c % 3) == 0);
            end
            if (wb_valid !== ((c % 3) == 2)) begin
                n_err++; chk($sformatf("b2b_wbv_c%0d", c), wb_valid, (c % 3) == 2);
            end
            if (c == 2 || c == 5) begin
                n_cmp++;
                if (wb_data !== ((c == 2) ? 4'd8 : 4'd0) || wb_rd !== 2'd2) begin
                    n_err++;
                    chk($sformatf("b2b_wb_c%0d", c), {wb_rd, wb_data}, (c == 2) ? 40 : 32);
                end
            end
            if (in_valid && in_ready) accepts++;
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if (accepts != 2) begin n_err++; chk("b2b_accepts", accepts, 2); end
        ref_r[2] = 0;
        // Separate dependent chain through the single-issue path.
        issue(1'b0, F_ADD, 2'd2, 2'd0, 2'd1, 1'b0, 4'd0, 8, "chain1");
        issue(1'b0, F_ADD, 2'd2, 2'd2, 2'd2, 1'b0, 4'd0, 0, "chain2");
    endtask

    task automatic test_reset_abort();
        issue(1'b1, F_AND, 2'd3, 2'd0, 2'd0, 1'b0, 4'd6, 6, "ld_r3");
        in_valid = 1'b1; in_ld = 1'b0; in_f = F_ADD; in_rd = 2'd2; in_ra = 2'd0;
        in_rb = 2'd1; in_imm_en = 1'b0;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        #1;
        n_cmp++;
        if (wb_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; chk("abort_during_rst", {wb_valid, in_ready}, 0);
        end
        tick();
        rst = 1'b0;
        #1;
        n_cmp += 2;
        if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; chk("abort_after_rst", {wb_valid, in_ready}, 1);
        end
        if ({alu_a, alu_b, alu_f} !== 11'd0) begin
            n_err++; chk("abort_alu_clear", {alu_a, alu_b, alu_f}, 0);
        end
        for (int i = 0; i < 4; i++) ref_r[i] = 0;
        // Reset and a valid instruction in the same cycle: nothing accepted.
        rst = 1'b1; in_valid = 1'b1; in_ld = 1'b1; in_rd = 2'd1; in_imm = 4'd7;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            n_cmp++;
            if (wb_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++; chk($sformatf("rst_vs_valid_c%0d", c), {wb_valid, in_ready}, 1);
            end
            tick();
        end
        issue(1'b0, F_OR,  2'd0, 2'd2, 2'd2, 1'b0, 4'd0, 0, "r2_cleared");
        issue(1'b0, F_ORN, 2'd0, 2'd3, 2'd1, 1'b1, 4'hF, 0, "r3_cleared");
        issue(1'b0, F_OR,  2'd0, 2'd1, 2'd0, 1'b0, 4'd0, 0, "r1_cleared");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            issue(($urandom_range(3) == 0), 3'($urandom), 2'($urandom), 2'($urandom),
                  2'($urandom), 1'($urandom), 4'($urandom), -1,
                  $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequential issue/write-back controller that sits directly upstream of the 4-bit combinational ALU and feeds it.
- Owns a 4x4-bit register file and accepts one instruction at a time over a valid/ready handshake.
- Drives registered A/B/F operands into the ALU, captures Y, and writes it back.
- Gives the combinational ALU a stable, clocked operand source and result sink.

Parameters:
N_REGS, 4, register file depth; fixed at 4 (2-bit indices).
WIDTH, 4, data width; must match the ALU operand width.

Ports:
clk  in  1  system clock; rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  instruction present.
in_ready  out  1  controller can accept an instruction.
in_ld  in  1  1 = load immediate into rd; 0 = ALU operation.
in_f  in  3  ALU function code, passed to alu_f.
in_rd  in  2  destination register index.
in_ra  in  2  operand A register index.
in_rb  in  2  operand B register index; ignored when in_imm_en=1.
in_imm_en  in  1  B operand taken from in_imm instead of register rb.
in_imm  in  4  immediate value.
alu_a  out  4  ALU operand A (registered).
alu_b  out  4  ALU operand B (registered).
alu_f  out  3  ALU function (registered).
alu_y  in  4  ALU result (combinational from alu_a/alu_b/alu_f).
wb_valid  out  1  one-cycle pulse: register write occurring this cycle.
wb_rd  out  2  register written.
wb_data  out  4  value written.

Behaviour:
- Reset values: all outputs are 0 on rst, except in_ready, which is 0 during the rst cycle and 1 in the first cycle after. The FSM goes to IDLE and all registers are cleared to 0.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch in_ld/in_f/in_rd/in_imm_en/in_imm, and load alu_a=R[ra] and alu_b = in_imm_en ? in_imm : R[rb], alu_f=in_f.
  - Go to EXEC. Call this the accept cycle t.
- EXEC (cycle t+1):
  - in_ready=0; alu_a/alu_b/alu_f are held stable.
  - At the end of the cycle, capture result = in_ld ? in_imm : alu_y.
  - Go to WB.
- WB (cycle t+2):
  - wb_valid=1, wb_rd=latched rd, wb_data=captured result.
  - R[rd] is updated at the end of the cycle.
  - Go to IDLE.
- Throughput and latency: the next accept is possible at t+3 and reads the updated register (no forwarding needed). Write-back latency is fixed at 2 cycles after accept; throughput is 1 instruction per 3 cycles.
- Handshake:
  - in_valid held high during EXEC/WB is ignored; the instruction is not consumed.
  - in_ready is combinational from the state (1 only in IDLE).
- ALU function encoding:
  - F[1:0]: 00 AND, 01 OR, 10 ADD/SUB, 11 compare.
  - F[2] inverts B for AND/OR, selects SUB for 10, and selects EQ (vs GT, unsigned) for 11.
  - Compare results arrive as {3'b000, flag}.
- Arithmetic: all arithmetic is modulo 16. Carry/borrow is discarded.
- alu_a/alu_b/alu_f are not cleared after WB; they retain their last values until the next accept.
- Boundary cases:
  - rd equal to ra or rb is legal; the operands were read at accept time.
  - in_ld=1 still traverses EXEC (uniform latency). alu_* are driven but alu_y is ignored.
  - rst asserted in any state aborts the instruction: no write-back, and the register file is cleared.
  - rst and in_valid in the same cycle: reset wins and nothing is accepted.

Decomposition:
- Shared package holds:
  - ALU function constants F_AND=000, F_OR=001, F_ADD=010, F_GT=011, F_ANDN=100, F_ORN=101, F_SUB=110, F_EQ=111.
  - FSM state encoding IDLE/EXEC/WB.
  - WIDTH.
- One sub-module, regfile_4x4:
  - 2 asynchronous read ports, 1 synchronous write port.
  - Synchronous active-high reset to zeros.

Test Plan:
- Load R0=5, R1=3 (in_ld), then ADD rd=2, ra=0, rb=1 -> wb_valid at t+2 with wb_rd=2, wb_data=8; alu_f=010 during EXEC.
- SUB rd=3, ra=1, rb=0 (3-5) -> wb_data=4'b1110 (14); ADD R0=9 with imm 9 -> wb_data=2 (wrap).
- GT ra=0 (5), rb=1 (3) -> wb_data=1; EQ with ra=rb=1 -> wb_data=1; EQ 5 vs 3 -> 0; ANDN 5 with imm 3 -> 4'b0100.
- in_valid held high for 6 cycles with two queued instructions -> exactly two accepts at t and t+3; in_ready low in EXEC/WB.
- rst asserted during EXEC of ADD rd=2 -> no wb_valid; R2 stays 0; in_ready=1 and all registers read 0 on the following cycle.
- Dependent chain: ADD R2=R0+R1, then ADD R2=R2+R2 immediately -> second result uses the updated R2 (8+8=0).
